// File: rtl/ext_arb_pkg.sv
// Shared types and constants for the external bus arbiter.
package ext_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  localparam int CNT_W = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester above last_grant, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] grant,
  output logic             valid
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest candidate down so the nearest requester wins last.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    cand  = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = IDX_W'((int'(last_grant) + i) % N_REQ);
      if (req[cand]) begin
        grant = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ext_bus_arbiter.sv
// Arbitrates N requesters onto one downstream bus with round-robin grant,
// one outstanding transaction, WAIT timeout and stray-ack detection.
module ext_bus_arbiter
  import ext_arb_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            m_req,
  input  logic [N_REQ-1:0]            m_req_is_wr,
  input  logic [N_REQ*ADDR_WIDTH-1:0] m_addr,
  input  logic [N_REQ*WIDTH-1:0]      m_wr_data,
  input  logic [N_REQ*WIDTH-1:0]      m_wr_biten,
  output logic [N_REQ-1:0]            m_rd_ack,
  output logic [N_REQ-1:0]            m_wr_ack,
  output logic [WIDTH-1:0]            m_rd_data,
  output logic                        m_err,
  output logic                        s_req,
  output logic                        s_req_is_wr,
  output logic [ADDR_WIDTH-1:0]       s_addr,
  output logic [WIDTH-1:0]            s_wr_data,
  output logic [WIDTH-1:0]            s_wr_biten,
  input  logic                        s_rd_ack,
  input  logic [WIDTH-1:0]            s_rd_data,
  input  logic                        s_wr_ack,
  output logic                        busy,
  output logic                        stray_ack
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_e              state_q, state_d;
  logic [IDX_W-1:0]        last_q, last_d;
  logic [IDX_W-1:0]        gnt_q, gnt_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    is_wr_q, is_wr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]        wdata_q, wdata_d;
  logic [WIDTH-1:0]        biten_q, biten_d;
  logic [N_REQ-1:0]        rd_ack_q, rd_ack_d;
  logic [N_REQ-1:0]        wr_ack_q, wr_ack_d;
  logic [WIDTH-1:0]        rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    stray_q, stray_d;

  logic [IDX_W-1:0]        rr_grant;
  logic                    rr_valid;
  logic                    any_ack, match_ack, wrong_ack, ack_cycle;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req        (m_req),
    .last_grant (last_q),
    .grant      (rr_grant),
    .valid      (rr_valid)
  );

  assign any_ack   = s_rd_ack | s_wr_ack;
  assign match_ack = is_wr_q ? s_wr_ack : s_rd_ack;
  assign wrong_ack = is_wr_q ? s_rd_ack : s_wr_ack;
  // The cycle carrying a requester ack is the mandatory idle gap.
  assign ack_cycle = (|rd_ack_q) | (|wr_ack_q);

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    is_wr_d  = is_wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    biten_d  = biten_q;
    rd_ack_d = '0;
    wr_ack_d = '0;
    rdata_d  = '0;
    err_d    = 1'b0;
    stray_d  = stray_q;
    case (state_q)
      IDLE: begin
        if (any_ack) stray_d = 1'b1;
        if (rr_valid && !ack_cycle) begin
          state_d = ISSUE;
          gnt_d   = rr_grant;
          last_d  = rr_grant;
          is_wr_d = m_req_is_wr[rr_grant];
          addr_d  = m_addr[int'(rr_grant)*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d = m_wr_data[int'(rr_grant)*WIDTH +: WIDTH];
          biten_d = m_wr_biten[int'(rr_grant)*WIDTH +: WIDTH];
        end
      end
      ISSUE: begin
        if (any_ack) stray_d = 1'b1;
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        if (wrong_ack) stray_d = 1'b1;
        if (match_ack || (cnt_q == CNT_W'(TIMEOUT - 1))) begin
          if (is_wr_q) wr_ack_d[gnt_q] = 1'b1;
          else         rd_ack_d[gnt_q] = 1'b1;
          rdata_d = (match_ack && !is_wr_q) ? s_rd_data : '0;
          err_d   = !match_ack;
          state_d = IDLE;
          cnt_d   = '0;
          is_wr_d = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          biten_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_q   <= IDX_W'(N_REQ - 1);
      gnt_q    <= '0;
      cnt_q    <= '0;
      is_wr_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      biten_q  <= '0;
      rd_ack_q <= '0;
      wr_ack_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      stray_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      is_wr_q  <= is_wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      biten_q  <= biten_d;
      rd_ack_q <= rd_ack_d;
      wr_ack_q <= wr_ack_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      stray_q  <= stray_d;
    end
  end

  assign s_req       = (state_q == ISSUE);
  assign s_req_is_wr = is_wr_q;
  assign s_addr      = addr_q;
  assign s_wr_data   = wdata_q;
  assign s_wr_biten  = biten_q;
  assign m_rd_ack    = rd_ack_q;
  assign m_wr_ack    = wr_ack_q;
  assign m_rd_data   = rdata_q;
  assign m_err       = err_q;
  assign busy        = (state_q != IDLE);
  assign stray_ack   = stray_q;

endmodule

// File: tb/tb_ext_bus_arbiter.sv
// Scoreboard bench for ext_bus_arbiter: directed transactions, downstream responder model.
module tb_ext_bus_arbiter;

  localparam int N  = 2;
  localparam int W  = 32;
  localparam int AW = 8;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    m_req;
  logic [N-1:0]    m_req_is_wr;
  logic [N*AW-1:0] m_addr;
  logic [N*W-1:0]  m_wr_data;
  logic [N*W-1:0]  m_wr_biten;
  logic [N-1:0]    m_rd_ack;
  logic [N-1:0]    m_wr_ack;
  logic [W-1:0]    m_rd_data;
  logic            m_err;
  logic            s_req;
  logic            s_req_is_wr;
  logic [AW-1:0]   s_addr;
  logic [W-1:0]    s_wr_data;
  logic [W-1:0]    s_wr_biten;
  logic            s_rd_ack;
  logic [W-1:0]    s_rd_data;
  logic            s_wr_ack;
  logic            busy;
  logic            stray_ack;

  ext_bus_arbiter #(.N_REQ(N), .WIDTH(W), .ADDR_WIDTH(AW), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req(m_req), .m_req_is_wr(m_req_is_wr), .m_addr(m_addr),
    .m_wr_data(m_wr_data), .m_wr_biten(m_wr_biten),
    .m_rd_ack(m_rd_ack), .m_wr_ack(m_wr_ack), .m_rd_data(m_rd_data), .m_err(m_err),
    .s_req(s_req), .s_req_is_wr(s_req_is_wr), .s_addr(s_addr),
    .s_wr_data(s_wr_data), .s_wr_biten(s_wr_biten),
    .s_rd_ack(s_rd_ack), .s_rd_data(s_rd_data), .s_wr_ack(s_wr_ack),
    .busy(busy), .stray_ack(stray_ack)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic          wr;
    logic [W-1:0]  wdata;
    logic [W-1:0]  biten;
  } iss_t;

  typedef struct {
    int           port;
    logic         wr;
    logic [W-1:0] data;
    logic         err;
  } rsp_t;

  iss_t exp_iss[$];
  rsp_t exp_rsp[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [112:0] all_out;
  assign all_out = {s_req, s_req_is_wr, s_addr, s_wr_data, s_wr_biten, m_rd_ack,
                    m_wr_ack, m_rd_data, m_err, busy, stray_ack};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream responder controls
  logic         dn_enable = 1'b1;
  int           dn_delay  = 2;
  int           inj_req   = 0;
  int           inj_done  = 0;
  logic [W-1:0] mem [256];

  initial begin
    int           pend;
    logic         pend_wr;
    logic [AW-1:0] pend_addr;
    pend = 0; pend_wr = 1'b0; pend_addr = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h04] = 32'hDEAD_BEEF;
    mem[8'h10] = 32'hA5A5_0010;
    mem[8'h20] = 32'h5A5A_0020;
    mem[8'h40] = 32'h4444_0040;
    s_rd_ack = 1'b0; s_wr_ack = 1'b0; s_rd_data = '0;
    forever begin
      @(negedge clk);
      s_rd_ack = 1'b0; s_wr_ack = 1'b0; s_rd_data = '0;
      if (inj_req != inj_done) begin
        inj_done = inj_done + 1;
        s_rd_ack = 1'b1;
        s_rd_data = 32'hBAD0_BAD0;
      end
      if (pend > 0) begin
        pend = pend - 1;
        if (pend == 0) begin
          if (pend_wr) s_wr_ack = 1'b1;
          else begin
            s_rd_ack = 1'b1;
            s_rd_data = mem[pend_addr];
          end
        end
      end else if (s_req && dn_enable && rst_n) begin
        pend = dn_delay;
        pend_wr = s_req_is_wr;
        pend_addr = s_addr;
        if (s_req_is_wr) mem[s_addr] = (mem[s_addr] & ~s_wr_biten) | (s_wr_data & s_wr_biten);
      end
    end
  end

  // Monitor: downstream issues, requester acks, idle-zero outputs
  initial begin
    logic prev_sreq;
    iss_t ei;
    rsp_t er;
    logic [N-1:0] xrd, xwr;
    prev_sreq = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_sreq = 1'b0;
        continue;
      end
      if (s_req) begin
        checks++;
        if (prev_sreq) begin
          errors++;
          $display("FAIL sreq_pulse: s_req high two cycles in a row, required single-cycle pulse");
        end
        checks++;
        if (exp_iss.size() == 0) begin
          errors++;
          $display("FAIL issue_unexpected: addr=%h wr=%b, required no issue", s_addr, s_req_is_wr);
        end else begin
          ei = exp_iss.pop_front();
          if (s_addr !== ei.addr || s_req_is_wr !== ei.wr || s_wr_data !== ei.wdata || s_wr_biten !== ei.biten) begin
            errors++;
            $display("FAIL issue: got addr=%h wr=%b data=%h biten=%h, required addr=%h wr=%b data=%h biten=%h",
                     s_addr, s_req_is_wr, s_wr_data, s_wr_biten, ei.addr, ei.wr, ei.wdata, ei.biten);
          end
        end
      end
      prev_sreq = s_req;
      checks++;
      if ((|m_rd_ack) || (|m_wr_ack)) begin
        if (exp_rsp.size() == 0) begin
          errors++;
          $display("FAIL ack_unexpected: rd_ack=%b wr_ack=%b, required none", m_rd_ack, m_wr_ack);
        end else begin
          er = exp_rsp.pop_front();
          xrd = er.wr ? '0 : N'(1 << er.port);
          xwr = er.wr ? N'(1 << er.port) : '0;
          if (m_rd_ack !== xrd || m_wr_ack !== xwr || m_rd_data !== er.data || m_err !== er.err) begin
            errors++;
            $display("FAIL ack: got rd=%b wr=%b data=%h err=%b, required rd=%b wr=%b data=%h err=%b",
                     m_rd_ack, m_wr_ack, m_rd_data, m_err, xrd, xwr, er.data, er.err);
          end
        end
      end else if (m_rd_data !== '0 || m_err !== 1'b0) begin
        errors++;
        $display("FAIL idle_zero: rd_data=%h err=%b without ack, required 0/0", m_rd_data, m_err);
      end
    end
  end

  task automatic set_port(input int p, input logic wr, input logic [AW-1:0] a,
                          input logic [W-1:0] d, input logic [W-1:0] be);
    m_req_is_wr[p]      = wr;
    m_addr[p*AW +: AW]  = a;
    m_wr_data[p*W +: W] = d;
    m_wr_biten[p*W +: W] = be;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic wr, input logic [W-1:0] d,
                      input logic [W-1:0] be, input int p, input logic [W-1:0] rd, input logic err);
    iss_t i;
    rsp_t r;
    i.addr = a; i.wr = wr; i.wdata = d; i.biten = be;
    r.port = p; r.wr = wr; r.data = rd; r.err = err;
    exp_iss.push_back(i);
    exp_rsp.push_back(r);
  endtask

  task automatic wait_sreq(output int c);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_req && n < 40);
    c = cyc;
    checks++;
    if (!s_req) begin
      errors++;
      $display("FAIL wait_sreq: no s_req within 40 cycles, required an issue");
    end
  endtask

  task automatic wait_ack(output int c);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((|m_rd_ack) || (|m_wr_ack)) && n < 60);
    c = cyc;
    checks++;
    if (!((|m_rd_ack) || (|m_wr_ack))) begin
      errors++;
      $display("FAIL wait_ack: no requester ack within 60 cycles, required an ack");
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1;
    rst_n = 1'b0;
    m_req = '0; m_req_is_wr = '0; m_addr = '0; m_wr_data = '0; m_wr_biten = '0;
    @(negedge clk);
    #1;
    check("reset_outputs", 128'(all_out), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // single read, port 0
    push(8'h04, 1'b0, '0, '0, 0, 32'hDEAD_BEEF, 1'b0);
    set_port(0, 1'b0, 8'h04, '0, '0);
    m_req[0] = 1'b1;
    wait_ack(c0);
    m_req = '0;
    repeat (3) @(negedge clk);

    // contention from reset: 0,1,0,1
    do_reset();
    dn_delay = 1;
    push(8'h10, 1'b0, '0, '0, 0, 32'hA5A5_0010, 1'b0);
    push(8'h20, 1'b0, '0, '0, 1, 32'h5A5A_0020, 1'b0);
    push(8'h10, 1'b0, '0, '0, 0, 32'hA5A5_0010, 1'b0);
    push(8'h20, 1'b0, '0, '0, 1, 32'h5A5A_0020, 1'b0);
    set_port(0, 1'b0, 8'h10, '0, '0);
    set_port(1, 1'b0, 8'h20, '0, '0);
    m_req = 2'b11;
    for (int k = 0; k < 4; k++) wait_ack(c0);
    m_req = '0;
    repeat (3) @(negedge clk);
    check("stray_clean", 128'(stray_ack), 128'd0);

    // masked write then readback, port 1
    dn_delay = 2;
    push(8'h08, 1'b1, 32'h1234_5678, 32'h0000_FFFF, 1, '0, 1'b0);
    set_port(1, 1'b1, 8'h08, 32'h1234_5678, 32'h0000_FFFF);
    m_req[1] = 1'b1;
    wait_ack(c0);
    m_req = '0;
    @(negedge clk);
    push(8'h08, 1'b0, '0, '0, 1, 32'h0000_5678, 1'b0);
    set_port(1, 1'b0, 8'h08, '0, '0);
    m_req[1] = 1'b1;
    wait_ack(c0);
    m_req = '0;
    repeat (3) @(negedge clk);

    // timeout and late ack
    do_reset();
    dn_enable = 1'b0;
    push(8'h30, 1'b0, '0, '0, 0, '0, 1'b1);
    set_port(0, 1'b0, 8'h30, '0, '0);
    m_req[0] = 1'b1;
    wait_sreq(c0);
    wait_ack(c1);
    m_req = '0;
    check("timeout_latency", 128'(c1 - c0), 128'd17);
    while (cyc < c0 + 20) @(negedge clk);
    inj_req = inj_req + 1;
    repeat (3) @(negedge clk);
    check("late_ack_stray", 128'(stray_ack), 128'd1);

    // reset mid-WAIT, then stray ack and port-0 priority
    do_reset();
    exp_iss.push_back('{addr: 8'h40, wr: 1'b0, wdata: '0, biten: '0});
    set_port(0, 1'b0, 8'h40, '0, '0);
    m_req[0] = 1'b1;
    wait_sreq(c0);
    repeat (3) @(negedge clk);
    check("busy_in_wait", 128'(busy), 128'd1);
    rst_n = 1'b0;
    m_req = '0;
    #1;
    check("midwait_reset_outputs", 128'(all_out), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    inj_req = inj_req + 1;
    repeat (3) @(negedge clk);
    check("post_reset_stray", 128'(stray_ack), 128'd1);
    check("post_reset_idle", 128'(busy), 128'd0);
    dn_enable = 1'b1;
    push(8'h10, 1'b0, '0, '0, 0, 32'hA5A5_0010, 1'b0);
    push(8'h20, 1'b0, '0, '0, 1, 32'h5A5A_0020, 1'b0);
    set_port(0, 1'b0, 8'h10, '0, '0);
    set_port(1, 1'b0, 8'h20, '0, '0);
    m_req = 2'b11;
    wait_ack(c0);
    m_req[0] = 1'b0;
    wait_ack(c0);
    m_req = '0;
    repeat (4) @(negedge clk);

    check("iss_queue_empty", 128'(exp_iss.size()), 128'd0);
    check("rsp_queue_empty", 128'(exp_rsp.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ext_bus_arbiter.md
EXT_BUS_ARBITER -- requirements
Module: ext_bus_arbiter

Interface
REQ-001 Parameters SHALL be: N_REQ, 2, number of requester ports (2..8); WIDTH, 32, data width; ADDR_WIDTH, 8, address width; TIMEOUT, 16, max WAIT cycles (1..255).
REQ-002 The block SHALL have one clock and an asynchronous active-low reset: clk input 1 (all flops rising-edge); rst_n input 1 (async assert, active low).
REQ-003 Requester ports SHALL be: m_req input N_REQ, level request held until ack; m_req_is_wr input N_REQ, 1 = write; m_addr input N_REQ*ADDR_WIDTH, per-port address; m_wr_data input N_REQ*WIDTH; m_wr_biten input N_REQ*WIDTH; m_rd_ack output N_REQ; m_wr_ack output N_REQ; m_rd_data output WIDTH, shared; m_err output 1, timeout flag, valid with ack.
REQ-004 Downstream ports SHALL be: s_req output 1, single-cycle pulse; s_req_is_wr output 1; s_addr output ADDR_WIDTH; s_wr_data output WIDTH; s_wr_biten output WIDTH; s_rd_ack input 1; s_rd_data input WIDTH; s_wr_ack input 1.
REQ-005 Status ports SHALL be: busy output 1, state != IDLE; stray_ack output 1, sticky, ack seen outside WAIT.

Function
REQ-006 FSM SHALL have states IDLE, ISSUE, WAIT.
REQ-007 IDLE: if any m_req bit set, grant one port by round-robin, register its is_wr/addr/wr_data/wr_biten, go ISSUE; otherwise stay.
REQ-008 Round-robin SHALL search from (last_grant+1) mod N_REQ upward; after reset last_grant = N_REQ-1, so port 0 has first priority.
REQ-009 ISSUE: s_req SHALL be 1 for exactly this cycle with registered fields on s_*, then go WAIT; s_* fields SHALL hold until return to IDLE.
REQ-010 WAIT: s_rd_ack (read) or s_wr_ack (write) SHALL produce, next cycle, a one-cycle m_rd_ack/m_wr_ack on the granted port only, m_rd_data = registered s_rd_data (reads) or 0 (writes), m_err = 0; FSM returns to IDLE.
REQ-011 Ack of the wrong type in WAIT SHALL be ignored and set stray_ack.
REQ-012 WAIT cycle counter SHALL start at 0 on entry; if it reaches TIMEOUT without a matching ack, the block SHALL pulse the granted port's ack with m_err = 1, m_rd_data = 0, and return to IDLE.
REQ-013 Ack in IDLE or ISSUE (including a late ack after timeout) SHALL be dropped and set stray_ack; stray_ack clears only on reset.
REQ-014 Minimum back-to-back spacing SHALL be one IDLE cycle after each ack; no grant in the ack cycle.
REQ-015 Requester deasserting m_req after grant SHALL NOT abort the transaction; the ack is still delivered.
REQ-016 m_rd_data, m_err SHALL be 0 whenever no ack is pulsed.

Reset
REQ-017 On rst_n low, state = IDLE, last_grant = N_REQ-1, counter = 0, and every output SHALL be 0 (s_*, m_*_ack, m_rd_data, m_err, busy, stray_ack).
REQ-018 Reset mid-transaction SHALL abandon it without ack; a subsequent downstream ack SHALL set stray_ack.

Structure
REQ-019 Package ext_arb_pkg SHALL hold the state enum (IDLE/ISSUE/WAIT) and TIMEOUT counter width constant (8 bits).
REQ-020 Round-robin grant logic SHALL be sub-module rr_arbiter (inputs req vector, last_grant; outputs grant index, valid), purely combinational.

Verification
REQ-021 Single read: port0 read addr 0x04, downstream acks after 2 cycles with 0xDEADBEEF -> s_req one pulse, m_rd_ack[0] one pulse, m_rd_data = 0xDEADBEEF, m_err = 0.
REQ-022 Contention: ports 0 and 1 request continuously from reset -> grants ordered 0,1,0,1; no port granted twice in a row.
REQ-023 Masked write: port1 write addr 0x08 data 0x12345678 biten 0x0000FFFF -> s_wr_data/s_wr_biten match, m_wr_ack[1] pulse, readback returns 0x00005678.
REQ-024 Timeout: downstream never acks -> m_rd_ack pulse exactly TIMEOUT (16) cycles after WAIT entry with m_err = 1, m_rd_data = 0; late ack at cycle 20 sets stray_ack.
REQ-025 Reset mid-WAIT: assert rst_n low for 1 cycle during WAIT -> all outputs 0 immediately, no m_*_ack, FSM IDLE, port 0 first priority afterwards.
